// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: controller states, byte width and
// the default sclk half-period.
package spi_pkg;

    localparam int BYTE_W          = 8;
    localparam int CLK_DIV_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT,
        TRAIL,
        GAP
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer: load starts a CLK_DIV-cycle interval and expire pulses
// for one cycle during its final clk cycle.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] count;
    logic       active;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 8'd0;
            active <= 1'b0;
        end else if (load) begin
            count  <= RELOAD;
            active <= 1'b1;
        end else if (expire) begin
            active <= 1'b0;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign expire = active && (count == 8'd0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master with byte handshake, frames delimited by tx_last, and a
// guaranteed slave-select gap between frames.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    state_t            state, state_next;
    logic              load, expire, accept;
    logic [BYTE_W-1:0] tx_shift, rx_shift;
    logic [2:0]        bit_cnt;
    logic              last;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .expire (expire)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (tx_valid && tx_ready) begin
                    accept     = 1'b1;
                    load       = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (expire) begin
                    load       = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (expire) begin
                    if (bit_cnt != 3'd7) begin
                        load       = 1'b1;
                        state_next = LOW;
                    end else if (last) begin
                        load       = 1'b1;
                        state_next = TRAIL;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            TRAIL: begin
                if (expire) begin
                    load       = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (expire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= 3'd0;
            last     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_next;
            rx_valid <= 1'b0;
            if (accept) begin
                tx_shift <= tx_data;
                last     <= tx_last;
                bit_cnt  <= 3'd0;
            end
            // Sample miso on the edge that raises sclk.
            if (state == LOW && expire) rx_shift <= {rx_shift[BYTE_W-2:0], spi_miso};
            if (state == HIGH && expire) begin
                if (bit_cnt != 3'd7) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                end else begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    // Outputs are registered copies of what the next state implies.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            spi_ss   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            tx_ready <= (state_next == IDLE) || (state_next == WAIT);
            busy     <= (state_next != IDLE);
            spi_ss   <= (state_next == IDLE) || (state_next == GAP);
            spi_sclk <= (state_next == HIGH);
            if (accept)
                spi_mosi <= tx_data[BYTE_W-1];
            else if (state == HIGH && state_next == LOW)
                spi_mosi <= tx_shift[BYTE_W-2];
            else if (state_next == IDLE || state_next == GAP)
                spi_mosi <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance with CLK_DIV=2, one with
// CLK_DIV=1, both wired in loopback (miso = mosi).
module tb_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tx_data2 = '0, tx_data1 = '0;
    logic       tx_valid2 = 0, tx_valid1 = 0, tx_last2 = 0, tx_last1 = 0;
    logic       tx_ready2, tx_ready1, rx_valid2, rx_valid1, busy2, busy1;
    logic [7:0] rx_data2, rx_data1;
    logic       sclk2, sclk1, ss2, ss1, mosi2, mosi1;

    spi_master #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_last(tx_last2), .tx_ready(tx_ready2), .rx_data(rx_data2),
        .rx_valid(rx_valid2), .busy(busy2), .spi_sclk(sclk2), .spi_ss(ss2),
        .spi_mosi(mosi2), .spi_miso(mosi2)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_last(tx_last1), .tx_ready(tx_ready1), .rx_data(rx_data1),
        .rx_valid(rx_valid1), .busy(busy1), .spi_sclk(sclk1), .spi_ss(ss1),
        .spi_mosi(mosi1), .spi_miso(mosi1)
    );

    // Event monitors, sampled on the falling edge.
    int         rise_q2[$], rise_q1[$];
    logic [7:0] rx_q2[$], rx_q1[$];
    logic [31:0] mosi_bits2 = '0, mosi_bits1 = '0;
    int  ss_fall_cyc2 = -1, ss_rise_cyc2 = -1, rx_cyc2 = -1, rdy_rise_cyc2 = -1;
    int  ss_falls2 = 0, ss_rises2 = 0;
    logic prev_sclk2 = 0, prev_sclk1 = 0, prev_ss2 = 1, prev_rdy2 = 0;

    always @(negedge clk) begin
        if (sclk2 && !prev_sclk2) begin
            rise_q2.push_back(cyc);
            mosi_bits2 = {mosi_bits2[30:0], mosi2};
        end
        if (sclk1 && !prev_sclk1) begin
            rise_q1.push_back(cyc);
            mosi_bits1 = {mosi_bits1[30:0], mosi1};
        end
        if (!ss2 && prev_ss2) begin ss_fall_cyc2 = cyc; ss_falls2++; end
        if (ss2 && !prev_ss2) begin ss_rise_cyc2 = cyc; ss_rises2++; end
        if (tx_ready2 && !prev_rdy2) rdy_rise_cyc2 = cyc;
        if (rx_valid2) begin rx_q2.push_back(rx_data2); rx_cyc2 = cyc; end
        if (rx_valid1) rx_q1.push_back(rx_data1);
        prev_sclk2 = sclk2;
        prev_sclk1 = sclk1;
        prev_ss2   = ss2;
        prev_rdy2  = tx_ready2;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    // Presents a byte and holds it until accepted; t0 is the accepting cycle.
    task automatic send(input int sel, input logic [7:0] d, input logic l, output int t0);
        bit ok = 0;
        t0 = -1;
        @(posedge clk); #1;
        if (sel == 1) begin tx_data1 = d; tx_last1 = l; tx_valid1 = 1; end
        else          begin tx_data2 = d; tx_last2 = l; tx_valid2 = 1; end
        for (int i = 0; i < 500 && !ok; i++) begin
            tick();
            if ((sel == 1) ? tx_ready1 : tx_ready2) begin ok = 1; t0 = cyc; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_accept byte=%02h got=not_accepted need=accepted", d);
        end
        @(posedge clk); #1;
        if (sel == 1) tx_valid1 = 0; else tx_valid2 = 0;
    endtask

    task automatic wait_idle(input int sel);
        bit done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            tick();
            if (sel == 1) done = !busy1 && tx_ready1;
            else          done = !busy2 && tx_ready2;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_idle dut=%0d got=busy need=idle", sel);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        tick();
        checks += 7;
        if (ss2 !== 1'b1)      begin failures++; $display("FAIL reset_ss got=%b need=1", ss2); end
        if (sclk2 !== 1'b0)    begin failures++; $display("FAIL reset_sclk got=%b need=0", sclk2); end
        if (mosi2 !== 1'b0)    begin failures++; $display("FAIL reset_mosi got=%b need=0", mosi2); end
        if (rx_valid2 !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b need=0", rx_valid2); end
        if (rx_data2 !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%02h need=00", rx_data2); end
        if (tx_ready2 !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b need=1", tx_ready2); end
        if (busy2 !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b need=0", busy2); end
    endtask

    task automatic test_timing();
        int t0;
        int r0 = rise_q2.size();
        int x0 = rx_q2.size();
        send(2, 8'h81, 1'b1, t0);
        wait_idle(2);
        checks += 7;
        if (ss_fall_cyc2 != t0 + 1)  begin failures++; $display("FAIL timing_ss_fall got=%0d need=%0d", ss_fall_cyc2 - t0, 1); end
        if (rise_q2[r0] != t0 + 3)   begin failures++; $display("FAIL timing_first_rise got=%0d need=%0d", rise_q2[r0] - t0, 3); end
        if (rx_cyc2 != t0 + 33)      begin failures++; $display("FAIL timing_rx_valid got=%0d need=%0d", rx_cyc2 - t0, 33); end
        if (ss_rise_cyc2 != t0 + 35) begin failures++; $display("FAIL timing_ss_rise got=%0d need=%0d", ss_rise_cyc2 - t0, 35); end
        if (rdy_rise_cyc2 != t0 + 37) begin failures++; $display("FAIL timing_tx_ready got=%0d need=%0d", rdy_rise_cyc2 - t0, 37); end
        if (rx_q2.size() != x0 + 1)  begin failures++; $display("FAIL timing_rx_count got=%0d need=1", rx_q2.size() - x0); end
        if (rx_q2[x0] !== 8'h81)     begin failures++; $display("FAIL timing_rx_data got=%02h need=81", rx_q2[x0]); end
    endtask

    task automatic test_back_to_back();
        int t0;
        int r0 = rise_q2.size();
        int x0 = rx_q2.size();
        int f0 = ss_falls2;
        int s0 = ss_rises2;
        send(2, 8'hf0, 1'b0, t0);
        send(2, 8'hff, 1'b0, t0);
        send(2, 8'h00, 1'b0, t0);
        send(2, 8'hff, 1'b1, t0);
        wait_idle(2);
        checks += 9;
        if (rise_q2.size() - r0 != 32) begin failures++; $display("FAIL frame_rises got=%0d need=32", rise_q2.size() - r0); end
        if (mosi_bits2 !== 32'hf0ff00ff) begin failures++; $display("FAIL frame_mosi got=%08h need=f0ff00ff", mosi_bits2); end
        if (ss_falls2 - f0 != 1) begin failures++; $display("FAIL frame_ss_falls got=%0d need=1", ss_falls2 - f0); end
        if (ss_rises2 - s0 != 1) begin failures++; $display("FAIL frame_ss_rises got=%0d need=1", ss_rises2 - s0); end
        if (ss_rise_cyc2 <= rise_q2[$]) begin failures++; $display("FAIL frame_ss_order got=%0d need>%0d", ss_rise_cyc2, rise_q2[$]); end
        if (rx_q2.size() - x0 != 4) begin failures++; $display("FAIL frame_rx_count got=%0d need=4", rx_q2.size() - x0); end
        if (rx_q2[x0] !== 8'hf0)   begin failures++; $display("FAIL frame_rx0 got=%02h need=f0", rx_q2[x0]); end
        if (rx_q2[x0+2] !== 8'h00) begin failures++; $display("FAIL frame_rx2 got=%02h need=00", rx_q2[x0+2]); end
        if (rx_q2[x0+3] !== 8'hff) begin failures++; $display("FAIL frame_rx3 got=%02h need=ff", rx_q2[x0+3]); end
    endtask

    task automatic test_loopback();
        int t0;
        int x0 = rx_q2.size();
        send(2, 8'h5a, 1'b0, t0);
        send(2, 8'ha5, 1'b1, t0);
        wait_idle(2);
        checks += 3;
        if (rx_q2.size() - x0 != 2) begin failures++; $display("FAIL loop_rx_count got=%0d need=2", rx_q2.size() - x0); end
        if (rx_q2[x0] !== 8'h5a)    begin failures++; $display("FAIL loop_rx0 got=%02h need=5a", rx_q2[x0]); end
        if (rx_q2[x0+1] !== 8'ha5)  begin failures++; $display("FAIL loop_rx1 got=%02h need=a5", rx_q2[x0+1]); end
    endtask

    // Second byte is presented throughout the gap; it may only be taken once
    // tx_ready returns, 37 cycles after the first acceptance.
    task automatic test_gap();
        int ta, tb;
        send(2, 8'h11, 1'b1, ta);
        send(2, 8'h22, 1'b1, tb);
        wait_idle(2);
        checks += 2;
        if (tb != ta + 37) begin failures++; $display("FAIL gap_accept got=%0d need=37", tb - ta); end
        if (ss_fall_cyc2 != tb + 1) begin failures++; $display("FAIL gap_ss_fall got=%0d need=%0d", ss_fall_cyc2 - tb, 1); end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit seen = 0;
        int r0 = rise_q2.size();
        int x0;
        send(2, 8'hc3, 1'b1, t0);
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            seen = (rise_q2.size() - r0 >= 3);
        end
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        x0 = rx_q2.size();
        tick();
        checks += 4;
        if (!seen)          begin failures++; $display("FAIL abort_third_rise got=missing need=seen"); end
        if (ss2 !== 1'b1)   begin failures++; $display("FAIL abort_ss got=%b need=1", ss2); end
        if (sclk2 !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b need=0", sclk2); end
        repeat (40) tick();
        if (rx_q2.size() != x0) begin failures++; $display("FAIL abort_rx_valid got=%0d need=0", rx_q2.size() - x0); end
        r0 = rise_q2.size();
        send(2, 8'h3c, 1'b1, t0);
        wait_idle(2);
        checks += 3;
        if (rise_q2.size() - r0 != 8) begin failures++; $display("FAIL after_abort_rises got=%0d need=8", rise_q2.size() - r0); end
        if (mosi_bits2[7:0] !== 8'h3c) begin failures++; $display("FAIL after_abort_mosi got=%02h need=3c", mosi_bits2[7:0]); end
        if (rx_q2.size() != x0 + 1 || rx_q2[x0] !== 8'h3c) begin
            failures++; $display("FAIL after_abort_rx got=%02h need=3c", rx_q2[x0]);
        end
    endtask

    task automatic test_div1();
        int t0;
        int r0 = rise_q1.size();
        int x0 = rx_q1.size();
        send(1, 8'h55, 1'b1, t0);
        wait_idle(1);
        checks += 5;
        if (rise_q1.size() - r0 != 8) begin failures++; $display("FAIL div1_rises got=%0d need=8", rise_q1.size() - r0); end
        if (rise_q1[r0] != t0 + 2) begin failures++; $display("FAIL div1_first_rise got=%0d need=2", rise_q1[r0] - t0); end
        if (rise_q1[r0+7] - rise_q1[r0] != 14) begin failures++; $display("FAIL div1_period got=%0d need=14", rise_q1[r0+7] - rise_q1[r0]); end
        if (mosi_bits1[7:0] !== 8'h55) begin failures++; $display("FAIL div1_mosi got=%02h need=55", mosi_bits1[7:0]); end
        if (rx_q1[x0] !== 8'h55) begin failures++; $display("FAIL div1_rx got=%02h need=55", rx_q1[x0]); end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_back_to_back();
        test_loopback();
        test_gap();
        test_reset_mid();
        test_div1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout need=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
